conv_pool_out: RTL and testbench

- Output stage directly downstream of the 49-tap convolution core.
- Consumes the core's 39-bit signed accumulator stream (16 fractional bits) and its valid strobe.
- Requantises each result to 16-bit Q8.8 with round-half-up and saturation, applies optional ReLU, then performs 2x2/stride-2 max pooling over a raster-ordered MAP_W x MAP_H feature map using a half-width line buffer.
- Emits one pooled Q8.8 word per 2x2 window, plus an end-of-map pulse.

---
 rtl/conv_pool_out.sv | 139 +++++++++++++
 tb/tb_conv_pool_out.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_out.sv
// Requantises conv-core accumulators to Q8.8 with optional ReLU.
// Then max-pools 2x2/stride-2 windows over a raster-ordered map, using a half-width line buffer.
module conv_pool_out #(
    parameter int IN_W  = 39,
    parameter int SHIFT = 8,
    parameter int OUT_W = 16,
    parameter int MAP_W = 26,
    parameter int MAP_H = 26,
    parameter int RELU  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    output logic                    map_done
);

    localparam int CW    = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int RW    = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int NPAIR = MAP_W / 2;
    localparam int LW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int QW    = IN_W - SHIFT + 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(MAP_W - 1);
    localparam logic [CW-1:0] COL_POOL_LAST = CW'(NPAIR * 2 - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(MAP_H - 1);
    localparam logic [RW-1:0] ROW_POOL_LAST = RW'((MAP_H / 2) * 2 - 1);

    localparam logic signed [IN_W:0] HALF   = (IN_W + 1)'(1) << (SHIFT - 1);
    localparam logic signed [QW-1:0] SAT_HI = QW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [QW-1:0] SAT_LO = QW'(-(2 ** (OUT_W - 1)));

    function automatic logic signed [OUT_W-1:0] sat_round(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] biased;
        logic signed [QW-1:0] q;
        biased = {x[IN_W-1], x} + HALF;
        q      = QW'(biased >>> SHIFT);
        if (q > SAT_HI)
            return SAT_HI[OUT_W-1:0];
        else if (q < SAT_LO)
            return SAT_LO[OUT_W-1:0];
        else
            return q[OUT_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] x);
        return (RELU != 0 && x < 0) ? '0 : x;
    endfunction

    function automatic logic signed [OUT_W-1:0] smax(input logic signed [OUT_W-1:0] a,
                                                     input logic signed [OUT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic signed [OUT_W-1:0] r_p1_q;
    logic                    vld_p1_q;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic signed [OUT_W-1:0] pair_q, pair_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    map_done_q, map_done_d;
    logic signed [OUT_W-1:0] lbuf_q [NPAIR];
    logic                    lb_we;
    logic signed [OUT_W-1:0] lb_wdata;
    logic [LW-1:0]           lb_idx;

    // Stage 1: requantise, saturate, rectify
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1_q <= 1'b0;
        else
            vld_p1_q <= in_valid;
        if (in_valid)
            r_p1_q <= relu(sat_round(in_data));
    end

    // Stage 2: raster position tracking and window max
    assign lb_idx   = LW'(col_q >> 1);
    assign lb_wdata = smax(pair_q, r_p1_q);

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        map_done_d  = 1'b0;
        lb_we       = 1'b0;
        if (vld_p1_q) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            // Even columns (including an odd-width trailing one) only load the pair register
            if (!col_q[0]) begin
                pair_d = r_p1_q;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_data_d  = smax(lbuf_q[lb_idx], lb_wdata);
                out_valid_d = 1'b1;
                map_done_d  = (row_q == ROW_POOL_LAST) && (col_q == COL_POOL_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            map_done_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            map_done_q  <= map_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we)
            lbuf_q[lb_idx] <= lb_wdata;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign map_done  = map_done_q;

endmodule

// File: tb/tb_conv_pool_out.sv
// Directed bench for conv_pool_out: four instances (2x2 ReLU, 2x2 linear, 4x4 ReLU, 5x3 ReLU)
// share one input stream; each sequence is checked cycle by cycle on the instance under test.
module tb_conv_pool_out;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic signed [38:0]       in_data = '0;
    logic                     in_valid = 1'b0;
    logic [3:0]               ov, md;
    logic [3:0][15:0]         od;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_pool_out #(.MAP_W(2), .MAP_H(2), .RELU(1)) u_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(od[0]), .out_valid(ov[0]), .map_done(md[0]));
    conv_pool_out #(.MAP_W(2), .MAP_H(2), .RELU(0)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(od[1]), .out_valid(ov[1]), .map_done(md[1]));
    conv_pool_out #(.MAP_W(4), .MAP_H(4), .RELU(1)) u_c (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(od[2]), .out_valid(ov[2]), .map_done(md[2]));
    conv_pool_out #(.MAP_W(5), .MAP_H(3), .RELU(1)) u_d (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(od[3]), .out_valid(ov[3]), .map_done(md[3]));

    // Per-step stimulus and expected-output schedule
    logic               sv  [300];
    logic               sr  [300];
    logic signed [38:0] sd  [300];
    logic               eov [302];
    logic [15:0]        eod [302];
    logic               emd [302];
    int n;

    typedef struct {
        int                 inst;
        logic signed [38:0] d0, d1, d2, d3;
        logic [15:0]        exp;
        string              nm;
    } vec_t;
    vec_t vt [11];

    task automatic chk(input string nm, input int j, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s step %0d got %0h want %0h", nm, j, got, want);
        end
    endtask

    task automatic clear_seq();
        n = 0;
        for (int i = 0; i < 302; i++) begin
            eov[i] = 1'b0;
            eod[i] = '0;
            emd[i] = 1'b0;
        end
    endtask

    // A sample pushed at step n with an expectation shows its strobe at step n+1
    task automatic push(input logic v, input logic signed [38:0] d, input logic r,
                        input logic e, input logic [15:0] ed, input logic edn);
        sv[n] = v;
        sd[n] = d;
        sr[n] = r;
        if (e) begin
            eov[n+1] = 1'b1;
            eod[n+1] = ed;
            emd[n+1] = edn;
        end
        n++;
    endtask

    task automatic smp(input logic signed [38:0] d);
        push(1'b1, d, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic smpx(input logic signed [38:0] d, input logic [15:0] ed, input logic edn);
        push(1'b1, d, 1'b0, 1'b1, ed, edn);
    endtask

    task automatic gap();
        push(1'b0, 39'sd0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int inst, input string nm);
        for (int j = 0; j <= n + 1; j++) begin
            if (j < n) begin
                in_valid = sv[j];
                in_data  = sd[j];
                rst      = sr[j];
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
                rst      = 1'b0;
            end
            @(negedge clk);
            chk({nm, " valid"}, j, 32'(ov[inst]), 32'(eov[j]));
            chk({nm, " done"}, j, 32'(md[inst]), 32'(eov[j] ? emd[j] : 1'b0));
            if (eov[j])
                chk({nm, " data"}, j, 32'(od[inst]), 32'(eod[j]));
        end
        rst = 1'b0;
    endtask

    task automatic set_vec(input int i, input int inst, input logic signed [38:0] a, input logic signed [38:0] b,
                           input logic signed [38:0] c, input logic signed [38:0] d,
                           input logic [15:0] e, input string nm);
        vt[i].inst = inst;
        vt[i].d0 = a;
        vt[i].d1 = b;
        vt[i].d2 = c;
        vt[i].d3 = d;
        vt[i].exp = e;
        vt[i].nm = nm;
    endtask

    task automatic seq_4x4(input int max_gap);
        for (int k = 0; k < 16; k++) begin
            if (k == 5 || k == 7 || k == 13 || k == 15)
                smpx(39'(k * 256), 16'(k), k == 15);
            else
                smp(39'(k * 256));
            for (int g = 0; g < max_gap; g++)
                if ($urandom_range(0, 1) == 1) gap();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        set_vec(0,  0, 384, 384, 384, 384, 16'h0002, "rnd384");
        set_vec(1,  0, 383, 383, 383, 383, 16'h0001, "rnd383");
        set_vec(2,  0, -384, -384, -384, -384, 16'h0000, "relu_neg");
        set_vec(3,  0, 256, 1792, 768, 512, 16'h0007, "max_mix");
        set_vec(4,  0, -512, -1280, -256, -2304, 16'h0000, "relu_negmax");
        set_vec(5,  1, 39'sd1 << 30, 39'sd1 << 30, 39'sd1 << 30, 39'sd1 << 30, 16'h7FFF, "sat_hi");
        set_vec(6,  1, -(39'sd1 << 30), -(39'sd1 << 30), -(39'sd1 << 30), -(39'sd1 << 30), 16'h8000, "sat_lo");
        set_vec(7,  1, -384, -384, -384, -384, 16'hFFFF, "neg_one");
        set_vec(8,  1, -512, -1280, -256, -2304, 16'hFFFF, "negmax");
        set_vec(9,  1, -129, -129, -129, -129, 16'hFFFF, "rnd_m129");
        set_vec(10, 1, -128, -129, -129, -129, 16'h0000, "rnd_m128");

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("reset out_valid", i, 32'(ov[i]), 32'd0);
            chk("reset out_data", i, 32'(od[i]), 32'd0);
            chk("reset map_done", i, 32'(md[i]), 32'd0);
        end

        // 2x2 single-window vectors
        for (int i = 0; i < 11; i++) begin
            do_reset();
            clear_seq();
            smp(vt[i].d0);
            smp(vt[i].d1);
            smp(vt[i].d2);
            smpx(vt[i].d3, vt[i].exp, 1'b1);
            run(vt[i].inst, vt[i].nm);
        end

        // 4x4 raster pooling, continuous
        do_reset();
        clear_seq();
        seq_4x4(0);
        run(2, "pool4x4");

        // 5x3 odd dims, two back-to-back frames
        do_reset();
        clear_seq();
        for (int i = 0; i < 15; i++) begin
            if (i == 6)      smpx(39'((i + 1) * 256), 16'd7, 1'b0);
            else if (i == 8) smpx(39'((i + 1) * 256), 16'd9, 1'b1);
            else             smp(39'((i + 1) * 256));
        end
        for (int i = 0; i < 15; i++) begin
            if (i == 6)      smpx(39'((20 - i) * 256), 16'd20, 1'b0);
            else if (i == 8) smpx(39'((20 - i) * 256), 16'd18, 1'b1);
            else             smp(39'((20 - i) * 256));
        end
        run(3, "odd5x3");

        // 4x4 with random idle gaps
        do_reset();
        clear_seq();
        seq_4x4(2);
        run(2, "gaps4x4");

        // Partial map cut by reset (in_valid high during reset), then a full map
        do_reset();
        clear_seq();
        for (int k = 0; k < 6; k++) smp(39'(k * 256));
        push(1'b1, 39'(99 * 256), 1'b1, 1'b0, 16'h0, 1'b0);
        seq_4x4(0);
        run(2, "midreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
